mst_seq_chk: RTL and testbench
==============================

# mst_seq_chk

Multi-channel streaming sequence checker for the FT600 master data path. It checks that each channel's received words form an incrementing count starting at zero, in 16-bit or 32-bit bus mode. For each channel it keeps the expected value, a sticky error flag, and saturating word and error counters. It also captures the first mismatch across all channels, and sits directly after the receive FIFO read port.

## Interface
Parameters:
- NUM_CH, 4, number of channels checked (1..4); CH_W = max(1, clog2(NUM_CH))
- DW, 32, data width (32 only supported; bus16 compares [15:0])
- CNT_W, 16, width of per-channel word and error counters

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- bus16  in  1  1 = compare rdata[15:0], 16-bit wrap; 0 = full 32-bit compare
- erdis  in  1  check disable; freezes all state, masks error outputs
- vld  in  1  rdata is a valid word for channel ch_id
- ch_id  in  CH_W  channel of current word; values ≥ NUM_CH are ignored
- rdata  in  DW  received word
- clr  in  NUM_CH  per-channel synchronous clear (expected, flag, counters)
- clr_fe  in  1  clear first-error capture
- stat_sel  in  CH_W  channel selected for counter readout
- seq_err  out  NUM_CH  per-channel sticky error & !erdis
- any_err  out  1  OR of seq_err
- word_cnt  out  CNT_W  words checked on stat_sel channel
- err_cnt  out  CNT_W  mismatches on stat_sel channel
- fe_vld  out  1  first-error capture valid
- fe_ch  out  CH_W  channel of first error
- fe_exp, fe_got  out  DW  expected and received value of first error

## Operation
- Each channel has its own state machine: RUN and HALT; reset and clr[i] put channel i in RUN.
- Reset/clr[i]: exp = 0, err = 0, word_cnt = 0, err_cnt = 0. All outputs reset to 0.
- Check event: vld & !erdis & ch_id == i & state RUN.
- Match condition: bus16 ? rdata[15:0] == exp[15:0] : rdata == exp.
- On match:
  - bus16: exp = {16'h0, exp[15:0] + 1}; 16'hFFFF wraps to 0.
  - 32-bit mode: exp + 1; 32'hFFFF_FFFF wraps to 0.
  - word_cnt increments, saturating at all-ones.
- On mismatch:
  - err = 1 (sticky until clr[i]); err_cnt and word_cnt increment, saturating.
  - Next state is set by the macro (see Configuration).
- First-error capture: on the first mismatch while fe_vld = 0, latch fe_ch, fe_exp, fe_got and set fe_vld. It holds until clr_fe or rst.
  - clr_fe together with a new mismatch: the new error is captured.
- Changing bus16 mid-stream is undefined; software clears channels after a mode change.
- In HALT the channel ignores vld; no counter changes.
- erdis = 1: no state changes of any kind; seq_err and any_err forced to 0. fe_* and counters are still readable.
- clr[i] together with a check event on channel i: the clear wins and the word is dropped.

## Timing
- Registered compare: seq_err, any_err, counters and fe_* update on the clock edge after the offending vld cycle (latency 1).
- word_cnt/err_cnt readout is combinational from stat_sel, over registered counters.
- One word accepted per cycle with no back-pressure; back-to-back words on the same channel are checked every cycle.
- seq_err drops combinationally when erdis rises.

## Configuration
- MST_CHK_RESYNC_EN defined:
  - A mismatch leaves the channel in RUN with exp = received + 1 (bus16: {16'h0, rdata[15:0] + 1}).
  - Later mismatches keep incrementing err_cnt; the err flag stays set.
- Undefined: a mismatch moves the channel to HALT and exp holds the expected value. This is legacy halt-on-first-error behaviour; err_cnt never exceeds 1 per clear.

## Structure
- Package mst_chk_pkg: state enum (RUN, HALT) and wrap constants (EXP16_MAX = 16'hFFFF, EXP32_MAX = 32'hFFFF_FFFF).
- The top module holds the ch_id decode, first-error capture and readout mux.
- Sub-module mst_seq_chk_ch holds one channel's expected value, state, flag and counters; it is instantiated NUM_CH times in a generate loop.

## Test plan
- Reset, then send ch0 words 0..9 in 32-bit mode: seq_err = 0, word_cnt = 10, err_cnt = 0.
- bus16 = 1, ch1 word sequence 16'hFFFE, FFFF, 0000 with exp preloaded by sending 0..FFFD: no error, wraps to 0.
- ch2 receives 0, 1, 5, 6:
  - seq_err[2] = 1 one cycle after the word 5.
  - fe_ch = 2, fe_exp = 2, fe_got = 5.
  - With the macro: err_cnt = 1 and 6 accepted. Without it: HALT, and word_cnt = 3 after the 6.
- erdis = 1 during a bad word on ch0: no error is flagged and counters are unchanged. seq_err stays masked until erdis falls, then reads the prior value.
- clr[3] asserted in the same cycle as vld on ch3 with a bad word: ch3 counters = 0 and seq_err[3] = 0 next cycle.
- Assert rst mid-stream with errors present on all channels: all outputs are 0 immediately (asynchronous), and the next word 0 on each channel passes.

Source files
------------

// File: rtl/mst_chk_pkg.sv
// Shared types and helpers for the FT600 master-path sequence checker.
// The channel state enum and the counter wrap points live here.
package mst_chk_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } ch_state_e;

    localparam logic [15:0] EXP16_MAX = 16'hFFFF;
    localparam logic [31:0] EXP32_MAX = 32'hFFFF_FFFF;

    // Successor of an expected word; 16-bit mode keeps the upper half at zero.
    function automatic logic [31:0] next_exp(input logic bus16, input logic [31:0] cur);
        logic [31:0] r;
        if (bus16) begin
            r = {16'h0, (cur[15:0] == EXP16_MAX) ? 16'h0 : cur[15:0] + 16'h1};
        end else begin
            r = (cur == EXP32_MAX) ? 32'h0 : cur + 32'h1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mst_seq_chk_if.sv
// Interface bundling the receive-word stream, control and status of mst_seq_chk.
// master drives words and controls; slave is the checker.
interface mst_seq_chk_if #(
    parameter int NUM_CH = 4,
    parameter int DW     = 32,
    parameter int CNT_W  = 16,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic              bus16;
    logic              erdis;
    logic              vld;
    logic [CH_W-1:0]   ch_id;
    logic [DW-1:0]     rdata;
    logic [NUM_CH-1:0] clr;
    logic              clr_fe;
    logic [CH_W-1:0]   stat_sel;

    logic [NUM_CH-1:0] seq_err;
    logic              any_err;
    logic [CNT_W-1:0]  word_cnt;
    logic [CNT_W-1:0]  err_cnt;
    logic              fe_vld;
    logic [CH_W-1:0]   fe_ch;
    logic [DW-1:0]     fe_exp;
    logic [DW-1:0]     fe_got;

    modport master (
        output bus16, erdis, vld, ch_id, rdata, clr, clr_fe, stat_sel,
        input  seq_err, any_err, word_cnt, err_cnt, fe_vld, fe_ch, fe_exp, fe_got
    );

    modport slave (
        input  bus16, erdis, vld, ch_id, rdata, clr, clr_fe, stat_sel,
        output seq_err, any_err, word_cnt, err_cnt, fe_vld, fe_ch, fe_exp, fe_got
    );
endinterface

// File: rtl/mst_seq_chk_ch.sv
// One checker channel: expected value, RUN/HALT state, sticky flag, saturating counters.
// MST_CHK_RESYNC_EN selects resync-on-mismatch instead of halt-on-first-error.
module mst_seq_chk_ch
    import mst_chk_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bus16,
    input  logic             erdis,
    input  logic             hit,
    input  logic [DW-1:0]    rdata,
    input  logic             clr,
    output logic             err_flag,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [DW-1:0]    exp_val,
    output logic             mism
);

    ch_state_e        state_reg, state_next;
    logic [DW-1:0]    exp_reg;
    logic             err_reg;
    logic [CNT_W-1:0] wc_reg, ec_reg;
    logic             chk_evt;
    logic             match;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (clr) begin
            state_next = RUN;
        end else if (mism) begin
`ifdef MST_CHK_RESYNC_EN
            state_next = RUN;
`else
            state_next = HALT;
`endif
        end
    end

    // A clear in the same cycle drops the word, so it never counts as a check.
    always_comb begin
        chk_evt = hit && !erdis && (state_reg == RUN) && !clr;
        match   = bus16 ? (rdata[15:0] == exp_reg[15:0]) : (rdata == exp_reg);
        mism    = chk_evt && !match;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_reg <= '0;
            err_reg <= 1'b0;
            wc_reg  <= '0;
            ec_reg  <= '0;
        end else if (clr) begin
            exp_reg <= '0;
            err_reg <= 1'b0;
            wc_reg  <= '0;
            ec_reg  <= '0;
        end else if (chk_evt) begin
            if (wc_reg != {CNT_W{1'b1}}) begin
                wc_reg <= wc_reg + 1'b1;
            end
            if (match) begin
                exp_reg <= next_exp(bus16, exp_reg);
            end else begin
                err_reg <= 1'b1;
                if (ec_reg != {CNT_W{1'b1}}) begin
                    ec_reg <= ec_reg + 1'b1;
                end
`ifdef MST_CHK_RESYNC_EN
                exp_reg <= next_exp(bus16, rdata);
`else
                exp_reg <= exp_reg;
`endif
            end
        end
    end

    assign err_flag = err_reg;
    assign word_cnt = wc_reg;
    assign err_cnt  = ec_reg;
    assign exp_val  = exp_reg;

endmodule

// File: rtl/mst_seq_chk.sv
// Multi-channel incrementing-count checker behind the FT600 receive FIFO read port.
// Build option MST_CHK_RESYNC_EN (see mst_seq_chk_ch) resyncs channels instead of halting them.
module mst_seq_chk
    import mst_chk_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DW     = 32,
    parameter int CNT_W  = 16
) (
    input  logic         clk,
    input  logic         rst,
    mst_seq_chk_if.slave bus
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] err_vec;
    logic [NUM_CH-1:0] mism_vec;
    logic [CNT_W-1:0]  wc_arr  [NUM_CH];
    logic [CNT_W-1:0]  ec_arr  [NUM_CH];
    logic [DW-1:0]     exp_arr [NUM_CH];

    logic              mism_any;
    logic [CH_W-1:0]   mism_ch;
    logic [DW-1:0]     mism_exp;

    logic              fe_vld_reg;
    logic [CH_W-1:0]   fe_ch_reg;
    logic [DW-1:0]     fe_exp_reg, fe_got_reg;

    // Channel ids at or above NUM_CH match no instance and are dropped.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            mst_seq_chk_ch #(
                .DW    (DW),
                .CNT_W (CNT_W)
            ) u_ch (
                .clk      (clk),
                .rst      (rst),
                .bus16    (bus.bus16),
                .erdis    (bus.erdis),
                .hit      (bus.vld && (bus.ch_id == CH_W'(gi))),
                .rdata    (bus.rdata),
                .clr      (bus.clr[gi]),
                .err_flag (err_vec[gi]),
                .word_cnt (wc_arr[gi]),
                .err_cnt  (ec_arr[gi]),
                .exp_val  (exp_arr[gi]),
                .mism     (mism_vec[gi])
            );
        end
    endgenerate

    // At most one channel can mismatch per cycle since only one ch_id is presented.
    always_comb begin
        mism_any = |mism_vec;
        mism_ch  = '0;
        mism_exp = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mism_vec[i]) begin
                mism_ch  = CH_W'(i);
                mism_exp = exp_arr[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fe_vld_reg <= 1'b0;
            fe_ch_reg  <= '0;
            fe_exp_reg <= '0;
            fe_got_reg <= '0;
        end else if (!bus.erdis) begin
            if (mism_any && (!fe_vld_reg || bus.clr_fe)) begin
                fe_vld_reg <= 1'b1;
                fe_ch_reg  <= mism_ch;
                fe_exp_reg <= mism_exp;
                fe_got_reg <= bus.rdata;
            end else if (bus.clr_fe) begin
                fe_vld_reg <= 1'b0;
                fe_ch_reg  <= '0;
                fe_exp_reg <= '0;
                fe_got_reg <= '0;
            end
        end
    end

    assign bus.seq_err  = err_vec & {NUM_CH{!bus.erdis}};
    assign bus.any_err  = |bus.seq_err;
    assign bus.word_cnt = (int'(bus.stat_sel) < NUM_CH) ? wc_arr[bus.stat_sel] : '0;
    assign bus.err_cnt  = (int'(bus.stat_sel) < NUM_CH) ? ec_arr[bus.stat_sel] : '0;
    assign bus.fe_vld   = fe_vld_reg;
    assign bus.fe_ch    = fe_ch_reg;
    assign bus.fe_exp   = fe_exp_reg;
    assign bus.fe_got   = fe_got_reg;

endmodule

// File: tb/tb_mst_seq_chk.sv
// Directed plus randomized check of mst_seq_chk against a per-channel sequence model.
module tb_mst_seq_chk;

    logic clk;
    logic rst;

    mst_seq_chk_if #(.NUM_CH(4), .DW(32), .CNT_W(16)) bus ();

    mst_seq_chk #(.NUM_CH(4), .DW(32), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_exp [4];
    bit          m_err [4];
    bit          m_halt[4];
    int          m_wc  [4];
    int          m_ec  [4];
    bit          m_fe_vld;
    int          m_fe_ch;
    logic [31:0] m_fe_exp, m_fe_got;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_exp[i] = 0; m_err[i] = 0; m_halt[i] = 0; m_wc[i] = 0; m_ec[i] = 0;
        end
        m_fe_vld = 0; m_fe_ch = 0; m_fe_exp = 0; m_fe_got = 0;
    endtask

    // Applies the rules to the inputs currently presented, for the coming edge.
    task automatic model_update();
        bit          mis = 0;
        int          mch = 0;
        logic [31:0] mexp = 0;
        bit          ok;
        for (int i = 0; i < 4; i++) begin
            if (bus.clr[i]) begin
                m_exp[i] = 0; m_err[i] = 0; m_halt[i] = 0; m_wc[i] = 0; m_ec[i] = 0;
            end else if (bus.vld && !bus.erdis && int'(bus.ch_id) == i && !m_halt[i]) begin
                ok = bus.bus16 ? (bus.rdata[15:0] == m_exp[i][15:0]) : (bus.rdata == m_exp[i]);
                if (m_wc[i] < 65535) m_wc[i]++;
                if (ok) begin
                    m_exp[i] = bus.bus16 ? ((m_exp[i] + 1) & 32'hFFFF) : (m_exp[i] + 1);
                end else begin
                    mis = 1; mch = i; mexp = m_exp[i];
                    m_err[i] = 1;
                    if (m_ec[i] < 65535) m_ec[i]++;
`ifdef MST_CHK_RESYNC_EN
                    m_exp[i] = bus.bus16 ? ((bus.rdata + 1) & 32'hFFFF) : (bus.rdata + 1);
`else
                    m_halt[i] = 1;
`endif
                end
            end
        end
        if (!bus.erdis) begin
            if (bus.clr_fe) begin
                m_fe_vld = 0; m_fe_ch = 0; m_fe_exp = 0; m_fe_got = 0;
            end
            if (mis && !m_fe_vld) begin
                m_fe_vld = 1; m_fe_ch = mch; m_fe_exp = mexp; m_fe_got = bus.rdata;
            end
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input logic [31:0] d);
        bus.vld   = 1'b1;
        bus.ch_id = ch[1:0];
        bus.rdata = d;
        tick();
        bus.vld   = 1'b0;
    endtask

    task automatic check_all(input string tag);
        logic [3:0] em;
        for (int i = 0; i < 4; i++) em[i] = m_err[i] & !bus.erdis;
        chk({tag, ".seq_err"}, 64'(bus.seq_err), 64'(em));
        chk({tag, ".any_err"}, 64'(bus.any_err), 64'(|em));
        chk({tag, ".fe_vld"}, 64'(bus.fe_vld), 64'(m_fe_vld));
        chk({tag, ".fe_ch"}, 64'(bus.fe_ch), 64'(m_fe_ch));
        chk({tag, ".fe_exp"}, 64'(bus.fe_exp), 64'(m_fe_exp));
        chk({tag, ".fe_got"}, 64'(bus.fe_got), 64'(m_fe_got));
        for (int i = 0; i < 4; i++) begin
            bus.stat_sel = i[1:0];
            #1;
            chk($sformatf("%s.word_cnt%0d", tag, i), 64'(bus.word_cnt), 64'(m_wc[i]));
            chk($sformatf("%s.err_cnt%0d", tag, i), 64'(bus.err_cnt), 64'(m_ec[i]));
        end
        $display("[TB] %s checked at %0t", tag, $time);
    endtask

    task automatic sel_cnt(input int ch, output logic [15:0] wc, output logic [15:0] ec);
        bus.stat_sel = ch[1:0];
        #1;
        wc = bus.word_cnt;
        ec = bus.err_cnt;
    endtask

    initial begin
        logic [15:0] wc, ec;
        int          ch;

        rst = 1'b1;
        bus.bus16 = 0; bus.erdis = 0; bus.vld = 0; bus.ch_id = 0; bus.rdata = 0;
        bus.clr = 0; bus.clr_fe = 0; bus.stat_sel = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_all("reset");

        // 32-bit mode, ch0 counts 0..9
        for (int k = 0; k < 10; k++) send(0, k);
        check_all("ch0_seq");
        sel_cnt(0, wc, ec);
        chk("ch0_wc10", 64'(wc), 64'd10);
        chk("ch0_ec0", 64'(ec), 64'd0);

        // 16-bit mode, ch1 runs through the 16-bit wrap
        bus.bus16 = 1; bus.clr = 4'b0010; tick(); bus.clr = 0;
        for (int k = 0; k <= 32'hFFFD; k++) send(1, k);
        send(1, 32'h0000_FFFE);
        send(1, 32'h0000_FFFF);
        send(1, 32'h0000_0000);
        check_all("ch1_wrap16");
        chk("ch1_noerr", 64'(bus.seq_err[1]), 64'd0);
        sel_cnt(1, wc, ec);
        chk("ch1_wc_sat", 64'(wc), 64'hFFFF);
        send(1, 32'h0000_0001);
        chk("ch1_after_wrap", 64'(bus.seq_err[1]), 64'd0);
        bus.bus16 = 0; bus.clr = 4'b0010; tick(); bus.clr = 0;

        // ch2 skips from 1 to 5
        send(2, 0); send(2, 1); send(2, 5);
        check_all("ch2_bad");
        chk("ch2_flag", 64'(bus.seq_err[2]), 64'd1);
        chk("ch2_fe_ch", 64'(bus.fe_ch), 64'd2);
        chk("ch2_fe_exp", 64'(bus.fe_exp), 64'd2);
        chk("ch2_fe_got", 64'(bus.fe_got), 64'd5);
        send(2, 6);
        check_all("ch2_after6");
        sel_cnt(2, wc, ec);
`ifdef MST_CHK_RESYNC_EN
        chk("ch2_ec", 64'(ec), 64'd1);
        chk("ch2_wc", 64'(wc), 64'd4);
`else
        chk("ch2_ec", 64'(ec), 64'd1);
        chk("ch2_wc", 64'(wc), 64'd3);
`endif

        // erdis masks flags and freezes everything
        bus.erdis = 1; #1;
        chk("erdis_mask", 64'(bus.seq_err), 64'd0);
        send(0, 99);
        check_all("erdis_bad");
        sel_cnt(0, wc, ec);
        chk("erdis_wc", 64'(wc), 64'd10);
        chk("erdis_ec", 64'(ec), 64'd0);
        bus.erdis = 0; #1;
        check_all("erdis_off");
        chk("erdis_prior", 64'(bus.seq_err), 64'b0100);

        // clear beats a same-cycle bad word on ch3
        send(3, 0); send(3, 1);
        bus.clr = 4'b1000; send(3, 77); bus.clr = 0;
        check_all("ch3_clr");
        sel_cnt(3, wc, ec);
        chk("ch3_wc0", 64'(wc), 64'd0);
        chk("ch3_flag0", 64'(bus.seq_err[3]), 64'd0);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            ch = $urandom_range(0, 3);
            bus.vld    = ($urandom_range(0, 3) != 0);
            bus.ch_id  = ch[1:0];
            bus.rdata  = ($urandom_range(0, 4) == 0) ? $urandom : m_exp[ch];
            bus.clr    = ($urandom_range(0, 19) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0;
            bus.clr_fe = ($urandom_range(0, 24) == 0);
            bus.erdis  = ($urandom_range(0, 29) == 0);
            tick();
            check_all($sformatf("rnd%0d", n));
        end
        bus.vld = 0; bus.clr = 0; bus.clr_fe = 0; bus.erdis = 0;

        // errors on every channel, then asynchronous reset mid-cycle
        bus.clr = 4'b1111; tick(); bus.clr = 0;
        for (int i = 0; i < 4; i++) send(i, 32'h55);
        check_all("all_err");
        chk("all_err_any", 64'(bus.seq_err), 64'hF);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_seq_err", 64'(bus.seq_err), 64'd0);
        chk("arst_any_err", 64'(bus.any_err), 64'd0);
        chk("arst_fe_vld", 64'(bus.fe_vld), 64'd0);
        chk("arst_fe_exp", 64'(bus.fe_exp), 64'd0);
        chk("arst_fe_got", 64'(bus.fe_got), 64'd0);
        for (int i = 0; i < 4; i++) begin
            sel_cnt(i, wc, ec);
            chk($sformatf("arst_wc%0d", i), 64'(wc), 64'd0);
            chk($sformatf("arst_ec%0d", i), 64'(ec), 64'd0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) send(i, 0);
        check_all("post_rst");
        chk("post_rst_ok", 64'(bus.seq_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
